// File: rtl/display_frame_integrator.sv
// Persistence-of-vision integrator: counts per-pixel hits over a burst
// of garbled display frames and thresholds them into one stable bitmap.
module display_frame_integrator #(
  parameter int WIDTH     = 56,
  parameter int HEIGHT    = 24,
  parameter int NB_FRAMES = 16,
  parameter int THRESHOLD = 12,
  parameter int CNT_W     = $clog2(NB_FRAMES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    frame_valid,
  output logic                    frame_ready,
  input  logic [WIDTH*HEIGHT-1:0] frame_pix,
  output logic                    busy,
  output logic [CNT_W-1:0]        frame_cnt,
  output logic [WIDTH*HEIGHT-1:0] bitmap_out,
  output logic                    bitmap_valid,
  output logic                    done
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NB_FRAMES - 1);
  localparam logic [CNT_W-1:0] THR  = CNT_W'(THRESHOLD);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESOLVE
  } state_t;

  state_t state;

  logic            clr;
  logic            accept;
  logic [NPIX-1:0] hit;

  // start wins over a frame offered in the same cycle
  assign frame_ready = (state == ACCUM) && !start;
  assign accept      = frame_valid && frame_ready;
  assign clr         = start && (state != RESOLVE);
  assign busy        = (state != IDLE);

  for (genvar i = 0; i < NPIX; i++) begin : g_pix
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (clr) begin
        cnt <= '0;
      end else if (accept && frame_pix[i]) begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign hit[i] = (cnt >= THR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      frame_cnt    <= '0;
      bitmap_out   <= '0;
      bitmap_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            frame_cnt    <= '0;
            bitmap_valid <= 1'b0;
            state        <= ACCUM;
          end
        end
        ACCUM: begin
          if (start) begin
            frame_cnt <= '0;
          end else if (frame_valid) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
            if (frame_cnt == LAST) begin
              state <= RESOLVE;
            end
          end
        end
        RESOLVE: begin
          bitmap_out   <= hit;
          bitmap_valid <= 1'b1;
          done         <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
